// File: rtl/keypad_pkg.sv
// Shared key/operator encodings and the keypad matrix map for the keypad entry path.
package keypad_pkg;

  localparam int NUM_W = 14;

  // Digit keys take the values 0..9 so the low bits double as the digit value.
  typedef enum logic [4:0] {
    K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
    K_A, K_B, K_C, K_D, K_STAR, K_HASH, K_NONE, K_MULTI
  } key_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  localparam key_t KEYMAP [4][4] = '{
    '{K1,     K2, K3,     K_A},
    '{K4,     K5, K6,     K_B},
    '{K7,     K8, K9,     K_C},
    '{K_STAR, K0, K_HASH, K_D}
  };

  function automatic logic is_digit(input key_t k);
    return (k <= K9);
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with 2-FF row synchroniser, per-scan key aggregation and debounce FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 2**16-1,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       key_accept,
  output key_t       key_code
);

  localparam int CNT_W = $clog2(SCAN_PERIOD + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

  logic [3:0]       row_meta, row_sync;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       hits_acc;
  key_t             code_acc;
  logic             sample;
  logic [2:0]       col_hits, hit_sum;
  key_t             col_code;
  logic [1:0]       tot_hits;
  key_t             tot_code, scan_result;

  logic             vld_p0;
  key_t             scan_res_p0;

  db_state_t        state, state_n;
  logic [DB_W-1:0]  db_cnt, db_cnt_n, db_inc;
  key_t             cand, cand_n;
  logic             res_is_key;

  assign col_o  = ~(4'b0001 << col_idx);
  assign sample = (dwell_cnt == CNT_W'(SCAN_PERIOD));

  // Hits are saturated at 2: that is already enough to call the scan MULTI.
  always_comb begin
    col_hits = 3'd0;
    col_code = K_NONE;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = KEYMAP[r][col_idx];
      end
    end
    hit_sum  = ((col_idx == 2'd0) ? 3'd0 : {1'b0, hits_acc}) + col_hits;
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code = (col_hits != 3'd0) ? col_code : code_acc;
    case (tot_hits)
      2'd0:    scan_result = K_NONE;
      2'd1:    scan_result = tot_code;
      default: scan_result = K_MULTI;
    endcase
  end

  // p0: one registered scan result per full 4-column scan
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      hits_acc  <= 2'd0;
      vld_p0    <= 1'b0;
    end else begin
      row_meta <= row_i;
      row_sync <= row_meta;
      vld_p0   <= 1'b0;
      if (sample) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        hits_acc  <= tot_hits;
        if (col_idx == 2'd3) vld_p0 <= 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample) begin
      code_acc <= tot_code;
      if (col_idx == 2'd3) scan_res_p0 <= scan_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      db_cnt <= '0;
      cand   <= K_NONE;
    end else begin
      state  <= state_n;
      db_cnt <= db_cnt_n;
      cand   <= cand_n;
    end
  end

  assign res_is_key = (scan_res_p0 != K_NONE) && (scan_res_p0 != K_MULTI);
  assign db_inc     = db_cnt + 1'b1;
  assign key_code   = cand;

  always_comb begin
    state_n    = state;
    db_cnt_n   = db_cnt;
    cand_n     = cand;
    key_accept = 1'b0;
    if (vld_p0) begin
      case (state)
        IDLE: if (res_is_key) begin
          cand_n   = scan_res_p0;
          db_cnt_n = DB_W'(1);
          state_n  = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (scan_res_p0 != cand) begin
            state_n = IDLE;
          end else if (db_inc == DB_W'(DEBOUNCE_SCANS)) begin
            key_accept = 1'b1;
            state_n    = HELD;
          end else begin
            db_cnt_n = db_inc;
          end
        end
        HELD: if (scan_res_p0 == K_NONE) begin
          db_cnt_n = DB_W'(1);
          state_n  = RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (scan_res_p0 != K_NONE)                state_n  = HELD;
          else if (db_inc == DB_W'(DEBOUNCE_SCANS)) state_n  = IDLE;
          else                                      db_cnt_n = db_inc;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: decimal accumulation plus operator/enter events.
// Build option KEYPAD_BACKSPACE_EN turns the D key into backspace instead of divide.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 2**16-1,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_i,
  output logic [3:0]       col_o,
  output logic [NUM_W-1:0] number_o,
  output logic [2:0]       digit_count_o,
  output logic             op_valid_o,
  output logic [1:0]       op_code_o,
  output logic             enter_o
);

  logic             key_accept;
  key_t             key_code;
  logic             new_entry;
  logic [NUM_W-1:0] base_num;
  logic [2:0]       base_cnt;

  keypad_scanner #(
    .SCAN_PERIOD    (SCAN_PERIOD),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .row_i      (row_i),
    .col_o      (col_o),
    .key_accept (key_accept),
    .key_code   (key_code)
  );

  // n*10 + d as shifts; the digit limit keeps 9999 from ever overflowing.
  function automatic logic [NUM_W-1:0] times10_add(input logic [NUM_W-1:0] n,
                                                   input logic [3:0] d);
    return (n << 3) + (n << 1) + {{(NUM_W-4){1'b0}}, d};
  endfunction

  assign base_num = new_entry ? '0 : number_o;
  assign base_cnt = new_entry ? 3'd0 : digit_count_o;

  // p1: outputs follow the cycle after the scanner accepts a key
  always_ff @(posedge clk) begin
    if (reset) begin
      number_o      <= '0;
      digit_count_o <= 3'd0;
      op_valid_o    <= 1'b0;
      op_code_o     <= 2'd0;
      enter_o       <= 1'b0;
      new_entry     <= 1'b0;
    end else begin
      op_valid_o <= 1'b0;
      enter_o    <= 1'b0;
      if (key_accept) begin
        if (is_digit(key_code)) begin
          new_entry <= 1'b0;
          if (base_cnt == 3'(MAX_DIGITS)) begin
            number_o      <= base_num;
            digit_count_o <= base_cnt;
          end else begin
            number_o      <= times10_add(base_num, key_code[3:0]);
            digit_count_o <= (base_num == '0 && key_code == K0) ? base_cnt : base_cnt + 3'd1;
          end
        end else begin
          case (key_code)
            K_STAR: begin
              number_o      <= '0;
              digit_count_o <= 3'd0;
              new_entry     <= 1'b0;
            end
            K_HASH: begin
              enter_o   <= 1'b1;
              new_entry <= 1'b1;
            end
            K_A: begin op_valid_o <= 1'b1; op_code_o <= OP_ADD; new_entry <= 1'b1; end
            K_B: begin op_valid_o <= 1'b1; op_code_o <= OP_SUB; new_entry <= 1'b1; end
            K_C: begin op_valid_o <= 1'b1; op_code_o <= OP_MUL; new_entry <= 1'b1; end
            K_D: begin
`ifdef KEYPAD_BACKSPACE_EN
              if (new_entry) begin
                new_entry <= 1'b0;
              end else begin
                number_o      <= number_o / NUM_W'(10);
                digit_count_o <= (digit_count_o == 3'd0) ? 3'd0 : digit_count_o - 3'd1;
              end
`else
              op_valid_o <= 1'b1;
              op_code_o  <= OP_DIV;
              new_entry  <= 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: table of key presses, corner sequences, then random keys vs a model.
module tb_keypad_entry;

  localparam int SP       = 3;
  localparam int DB       = 2;
  localparam int SCAN_CYC = 4 * (SP + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [13:0] number_o;
  logic [2:0]  digit_count_o;
  logic        op_valid_o;
  logic [1:0]  op_code_o;
  logic        enter_o;

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_PERIOD(SP), .DEBOUNCE_SCANS(DB), .MAX_DIGITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .row_i         (row_i),
    .col_o         (col_o),
    .number_o      (number_o),
    .digit_count_o (digit_count_o),
    .op_valid_o    (op_valid_o),
    .op_code_o     (op_code_o),
    .enter_o       (enter_o)
  );

  // Physical keypad: a pressed key shorts its row to its column.
  logic [3:0][3:0] pressed;
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_o[c]) row_i[r] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int enter_seen = 0;
  int op_seen = 0;
  int last_code = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (enter_o) enter_seen++;
      if (op_valid_o) begin
        op_seen++;
        last_code = op_code_o;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void key_pos(input byte k, output int r, output int c);
    r = 0; c = 0;
    case (k)
      "1": begin r = 0; c = 0; end  "2": begin r = 0; c = 1; end
      "3": begin r = 0; c = 2; end  "A": begin r = 0; c = 3; end
      "4": begin r = 1; c = 0; end  "5": begin r = 1; c = 1; end
      "6": begin r = 1; c = 2; end  "B": begin r = 1; c = 3; end
      "7": begin r = 2; c = 0; end  "8": begin r = 2; c = 1; end
      "9": begin r = 2; c = 2; end  "C": begin r = 2; c = 3; end
      "*": begin r = 3; c = 0; end  "0": begin r = 3; c = 1; end
      "#": begin r = 3; c = 2; end  "D": begin r = 3; c = 3; end
      default: ;
    endcase
  endfunction

  // Reference model of the calculator entry rules.
  int m_num = 0;
  int m_cnt = 0;
  bit m_new = 0;

  task automatic model_apply(input byte k, output int e_enter, output int e_op, output int e_code);
    int d;
    e_enter = 0; e_op = 0; e_code = 0;
    if (k >= "0" && k <= "9") begin
      d = k - "0";
      if (m_new) begin m_num = 0; m_cnt = 0; m_new = 0; end
      if (m_cnt < 4) begin
        if (!(m_num == 0 && d == 0)) m_cnt++;
        m_num = m_num * 10 + d;
      end
    end else begin
      case (k)
        "*": begin m_num = 0; m_cnt = 0; m_new = 0; end
        "#": begin e_enter = 1; m_new = 1; end
        "A", "B", "C": begin e_op = 1; e_code = k - "A"; m_new = 1; end
        "D": begin
`ifdef KEYPAD_BACKSPACE_EN
          if (m_new) m_new = 0;
          else begin
            m_num = m_num / 10;
            if (m_cnt > 0) m_cnt--;
          end
`else
          e_op = 1; e_code = 3; m_new = 1;
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic press(input byte k, input int hold_cyc, input int rel_cyc);
    int r, c;
    key_pos(k, r, c);
    pressed[r][c] = 1'b1;
    repeat (hold_cyc) @(negedge clk);
    pressed[r][c] = 1'b0;
    repeat (rel_cyc) @(negedge clk);
  endtask

  // Press one key cleanly and compare the DUT against the model.
  task automatic do_key(input byte k);
    int e0, o0, ee, eo, ec;
    e0 = enter_seen; o0 = op_seen;
    press(k, 3 * SCAN_CYC + $urandom_range(0, 15), 3 * SCAN_CYC + $urandom_range(0, 15));
    model_apply(k, ee, eo, ec);
    check($sformatf("rand_num[%c]", k), number_o, m_num);
    check($sformatf("rand_cnt[%c]", k), digit_count_o, m_cnt);
    check($sformatf("rand_enter[%c]", k), enter_seen - e0, ee);
    check($sformatf("rand_op[%c]", k), op_seen - o0, eo);
    if (eo == 1) check($sformatf("rand_code[%c]", k), last_code, ec);
  endtask

  typedef struct {
    byte key;
    int  num;
    int  cnt;
    int  enter;
    int  op;
    int  code;
  } vec_t;

  vec_t vecs [$];
  byte  rand_keys [16] = '{"0","1","2","3","4","5","6","7","8","9","A","B","C","D","*","#"};

  initial begin
    int e0, o0, ee, eo, ec, guard;
    logic [3:0] prev_col;

    vecs = '{
      '{"1", 1, 1, 0, 0, 0},    '{"2", 12, 2, 0, 0, 0},   '{"3", 123, 3, 0, 0, 0},
      '{"4", 1234, 4, 0, 0, 0}, '{"5", 1234, 4, 0, 0, 0}, '{"*", 0, 0, 0, 0, 0},
      '{"0", 0, 0, 0, 0, 0},    '{"0", 0, 0, 0, 0, 0},    '{"7", 7, 1, 0, 0, 0},
      '{"#", 7, 1, 1, 0, 0},    '{"9", 9, 1, 0, 0, 0},    '{"*", 0, 0, 0, 0, 0},
      '{"4", 4, 1, 0, 0, 0},    '{"B", 4, 1, 0, 1, 1},    '{"*", 0, 0, 0, 0, 0}
    };

    pressed = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_col", col_o, 4'b1110);
    check("reset_num", number_o, 0);
    check("reset_cnt", digit_count_o, 0);
    check("reset_op_valid", op_valid_o, 0);
    check("reset_op_code", op_code_o, 0);
    check("reset_enter", enter_o, 0);

    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("col_seq[%0d]", i), col_o, 4'hF & ~(4'b0001 << ((i / 4) % 4)));
      @(negedge clk);
    end
    check("idle_num", number_o, 0);
    check("idle_pulses", enter_seen + op_seen, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      e0 = enter_seen; o0 = op_seen;
      press(vecs[i].key, 3 * SCAN_CYC, 3 * SCAN_CYC);
      model_apply(vecs[i].key, ee, eo, ec);
      check($sformatf("tbl_num[%0d]", i), number_o, vecs[i].num);
      check($sformatf("tbl_cnt[%0d]", i), digit_count_o, vecs[i].cnt);
      check($sformatf("tbl_enter[%0d]", i), enter_seen - e0, vecs[i].enter);
      check($sformatf("tbl_op[%0d]", i), op_seen - o0, vecs[i].op);
      if (vecs[i].op == 1) check($sformatf("tbl_code[%0d]", i), last_code, vecs[i].code);
    end

    // Two keys together: MULTI, no event at all.
    e0 = enter_seen; o0 = op_seen;
    pressed[0][0] = 1'b1; pressed[0][1] = 1'b1;
    repeat (4 * SCAN_CYC) @(negedge clk);
    pressed = '0;
    repeat (4 * SCAN_CYC) @(negedge clk);
    check("multi_num", number_o, m_num);
    check("multi_cnt", digit_count_o, m_cnt);
    check("multi_pulses", (enter_seen - e0) + (op_seen - o0), 0);

    // Bouncing 5: present on alternate scans only, then stable for 2 scans.
    for (int i = 0; i < 4; i++) begin
      pressed[1][1] = (i % 2 == 0);
      repeat (SCAN_CYC) @(negedge clk);
    end
    pressed[1][1] = 1'b1;
    repeat (2 * SCAN_CYC) @(negedge clk);
    pressed[1][1] = 1'b0;
    repeat (4 * SCAN_CYC) @(negedge clk);
    model_apply("5", ee, eo, ec);
    check("bounce_num", number_o, 5);
    check("bounce_cnt", digit_count_o, 1);

    // Reset while 8 is in PRESS_WAIT: align to a scan start first.
    guard = 0;
    prev_col = col_o;
    @(negedge clk);
    while (!(col_o == 4'b1110 && prev_col == 4'b0111) && guard < 64) begin
      prev_col = col_o;
      @(negedge clk);
      guard++;
    end
    check("align_timeout", guard < 64, 1);
    pressed[2][1] = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_col", col_o, 4'b1110);
    check("midrst_num", number_o, 0);
    check("midrst_cnt", digit_count_o, 0);
    reset = 1'b0;
    m_num = 0; m_cnt = 0; m_new = 0;
    repeat (20) @(negedge clk);
    check("midrst_no_early_accept", number_o, 0);
    repeat (3 * SCAN_CYC) @(negedge clk);
    pressed[2][1] = 1'b0;
    repeat (4 * SCAN_CYC) @(negedge clk);
    model_apply("8", ee, eo, ec);
    check("postrst_num", number_o, 8);
    check("postrst_cnt", digit_count_o, 1);

`ifdef KEYPAD_BACKSPACE_EN
    do_key("*");
    do_key("8");
    do_key("3");
    do_key("D");
    check("bksp_num", number_o, 8);
    check("bksp_cnt", digit_count_o, 1);
`endif

    for (int i = 0; i < 30; i++) do_key(rand_keys[$urandom_range(0, 15)]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the calculator's 7-segment display path.
- Scans a 4x4 matrix keypad, debounces it, and turns decimal key presses into a 14-bit binary number (0..9999) for the calculator core.
- Operator, enter and clear keys are reported as single-cycle events.
- Sits between the board keypad pins and the calculator datapath that feeds the display.

Parameters:
- SCAN_PERIOD, 2**16-1: column dwell time minus 1, in clk cycles; must be >= 3.
- DEBOUNCE_SCANS, 4: number of consecutive full 4-column scans needed to accept a press or a release.
- MAX_DIGITS, 4: maximum number of significant digits that can be entered.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- row_i  in  4  keypad rows; active-low, pulled up externally; asynchronous to clk
- col_o  out  4  keypad columns; active-low, exactly one low at any time
- number_o  out  14  number currently being entered
- digit_count_o  out  3  significant digits currently held in number_o
- op_valid_o  out  1  one-cycle pulse: an operator key was accepted
- op_code_o  out  2  operator code; valid with op_valid_o: 0=+ (A), 1=- (B), 2=* (C), 3=/ (D)
- enter_o  out  1  one-cycle pulse: # key accepted

Behaviour:
- Reset values: col_o=4'b1110, number_o=0, digit_count_o=0, op_valid_o=0, op_code_o=0, enter_o=0; scan counter=0; debounce FSM in IDLE.
- Key map, row r / column c: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
- Synchroniser: row_i passes through a 2-FF synchroniser before use.
- Scan:
  - col_o drives each column low for SCAN_PERIOD+1 cycles, in order 0,1,2,3, then wraps.
  - Rows are sampled on the last cycle of each dwell.
  - One full scan = 4 dwells.
- Scan result, per full scan: exactly one low row-sample across all 4 columns gives that key code; zero low samples gives NONE; two or more gives MULTI.
- Debounce FSM:
  - IDLE: on a valid key code, capture it, set count=1 and go to PRESS_WAIT.
  - PRESS_WAIT:
    - Same code on the next scan: count+1.
    - When count reaches DEBOUNCE_SCANS: raise accept (one cycle) and go to HELD.
    - Any other result: return to IDLE.
  - HELD:
    - NONE: count=1, go to RELEASE_WAIT.
    - Anything else, including a different key or MULTI: stay; no new event.
  - RELEASE_WAIT:
    - NONE for DEBOUNCE_SCANS scans total: go to IDLE.
    - Any key result: back to HELD.
  - MULTI never generates an event.
- Accept handling: outputs update, and pulses assert, on the cycle after accept. Pulses last exactly one cycle.
- Digit d accepted:
  - If a "new entry" flag is set (after enter or an operator), first clear number and count, then apply d.
  - If digit_count=MAX_DIGITS: ignore d.
  - Otherwise: number = number*10 + d, computed as (n<<3)+(n<<1)+d in 14 bits; 9999 cannot overflow.
  - digit_count increments unless number was 0 and d=0 (leading zeros are not counted; number stays 0).
- * key: number=0, digit_count=0, new-entry flag cleared; no pulse.
- # key: enter_o=1 for one cycle; number_o unchanged; new-entry flag set.
- A/B/C/D keys: op_valid_o=1 with op_code_o for one cycle; number_o unchanged; new-entry flag set.
- Reset mid-scan or mid-debounce: all state returns to reset values on the next edge; a key still held after reset must pass the full debounce again before producing an event.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined:
  - D key is backspace: number = number/10, digit_count = digit_count-1 (floored at 0); no op pulse.
  - op_code_o=3 is never produced.
  - If the new-entry flag is set, backspace clears the flag and does nothing else.
- Undefined: D key is the divide operator, as described above.

Decomposition:
- Package keypad_pkg:
  - key_t enum (K0..K9, K_A, K_B, K_C, K_D, K_STAR, K_HASH, K_NONE, K_MULTI).
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - Constants NUM_W=14, KEYMAP row/column lookup.
- Sub-module keypad_scanner:
  - Contains the synchroniser, column counter, scan aggregation and debounce FSM.
  - Outputs key_accept (pulse) and key_code (key_t).
- keypad_entry: instantiates keypad_scanner and holds the number-accumulation and event logic.

Test Plan:
All scenarios use SCAN_PERIOD=3 and DEBOUNCE_SCANS=2.
- After reset, no key pressed -> col_o steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; number_o=0; no pulses.
- Press 1, 2, 3, 4, 5, each held 3 scans then released 3 scans -> number_o=1234, digit_count_o=4; the 5 is ignored.
- Press 0, 0, 7 -> number_o=7, digit_count_o=1. Press # -> enter_o pulses exactly once. Press 9 -> number_o=9.
- Press 4, then B -> op_valid_o pulses once with op_code_o=1; number_o stays 4. Press * -> number_o=0, digit_count_o=0.
- Bouncing 5: row toggles on alternate scans for 4 scans, then stable for 2 scans -> exactly one accept; number_o=5. Keys 1 and 2 held together -> no event.
- Hold 8 and assert reset during PRESS_WAIT -> outputs return to reset values; 8 is accepted once after 2 clean scans post-reset. With KEYPAD_BACKSPACE_EN, entering 8, 3 then D -> number_o=8, digit_count_o=1.
